lsu_axi_bridge: RTL
===================

# lsu_axi_bridge

Converts the LSU's single-outstanding memory port (io_* handshake) into an AXI4-Lite-style master with independent read and write channels. It sits directly downstream of the LSU, between the LSU and the SoC interconnect. It latches each one-cycle LSU request, runs the corresponding AXI transaction, and returns a one-cycle response pulse with read data. Lane alignment, misaligned-access splitting and sign extension remain in the LSU; this block passes raw 32-bit lanes.

## Interface
- No parameters.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-low reset
- io_reqValid  in  1  one-cycle request pulse from the LSU
- io_respValid  out  1  one-cycle completion pulse to the LSU
- io_addr  in  32  byte address, passed unmodified
- io_size  in  2  00 byte, 01 half, 10 word, 11 word
- io_wen  in  1  1 = write, 0 = read
- io_wdata  in  32  lane-aligned write data
- io_wmask  in  4  byte lane strobes
- io_rdata  out  32  raw read word
- io_err  out  1  error flag, valid with io_respValid
- awvalid/awready, awaddr[31:0], awsize[2:0]  write address channel
- wvalid/wready, wdata[31:0], wstrb[3:0]  write data channel
- bvalid/bready, bresp[1:0]  write response channel
- arvalid/arready, araddr[31:0], arsize[2:0]  read address channel
- rvalid/rready, rdata[31:0], rresp[1:0]  read data channel

## Operation
- States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, RESP.
- IDLE: when io_reqValid=1, register addr, size, wen, wdata and wmask.
  - If wen=0, go to RD_ADDR; else go to WR_REQ.
  - io_reqValid in any other state is ignored and is not queued. The LSU guarantees at most one request is outstanding.
- RD_ADDR: arvalid=1 with the registered araddr/arsize. On arready, go to RD_DATA.
- RD_DATA: rready=1. On rvalid, capture rdata into io_rdata and go to RESP.
- WR_REQ: awvalid and wvalid both asserted.
  - Each channel deasserts independently once its own handshake completes; either order, or both in the same cycle, is allowed.
  - When both handshakes are complete, go to WR_RESP.
- WR_RESP: bready=1. On bvalid, go to RESP.
- RESP: io_respValid=1 for exactly one cycle, then go to IDLE. io_rdata holds its value until the next read capture.
- Size mapping: io_size 00 maps to 3'b000, 01 to 3'b001, 10 and 11 to 3'b010.
- wstrb is copied from io_wmask, wdata from io_wdata, and awaddr/araddr from io_addr. No alignment is applied.
- Valid signals never drop before their handshake completes; AXI stability rules apply.
- Reset (reset=0 at a clock edge), including mid-transaction: return to IDLE.
  - All outputs go to 0: valids, readies, io_respValid, io_err, io_rdata and the address/data buses.
  - The in-flight AXI transaction is abandoned. The system resets the interconnect with the same signal.

## Timing
- All outputs are registered.
- Read with zero-wait slave (arready=1; rvalid one cycle after AR):
  - cycle 0: io_reqValid
  - cycle 1: AR handshake
  - cycle 2: R handshake
  - cycle 3: io_respValid
- Write with zero-wait slave: cycle 1 AW+W handshake, cycle 2 B handshake, cycle 3 io_respValid.
- Minimum latency from request to response is 3 cycles. Each slave wait cycle on any channel adds exactly one cycle.
- A new io_reqValid is accepted in the cycle after RESP, when the state is IDLE. Back-to-back throughput is 4 cycles per access.

## Configuration
- LSU_AXI_BRIDGE_ERR_EN defined:
  - rresp or bresp not equal to 2'b00 sets io_err=1 in the RESP cycle.
  - A read with an error forces io_rdata to 32'h0.
- LSU_AXI_BRIDGE_ERR_EN undefined:
  - rresp and bresp are ignored; io_err is tied to 0.
  - io_rdata always takes rdata.

## Structure
- Package lsu_axi_bridge_pkg holds:
  - the state enum
  - AXI response constants: OKAY, EXOKAY, SLVERR, DECERR
  - AXI size constants
  - the io_size-to-AXI-size mapping function
- One sub-module, axi_aw_w_join, contains the two "accepted" flags for AW and W. It drives awvalid/wvalid and signals done when both are accepted.

## Test plan
- Read, zero-wait slave:
  - stimulus: addr 0x8000_0004, rdata 0xCAFE_F00D
  - required: araddr=0x8000_0004, arsize=010, io_respValid in cycle 3, io_rdata=0xCAFE_F00D.
- Write with W accepted 2 cycles before AW:
  - stimulus: wdata 0x1234_5678, wmask 0110
  - required: wstrb=0110; wvalid drops after its own handshake while awvalid stays high; io_respValid follows B by 1 cycle.
- Slave stalls:
  - stimulus: arready low for 3 cycles, rvalid low for 2 cycles
  - required: arvalid/araddr stable throughout; response at cycle 8.
- Request while busy:
  - stimulus: second io_reqValid during RD_DATA
  - required: ignored; exactly one AR issued and one io_respValid.
- Reset mid-write:
  - stimulus: reset=0 during WR_RESP
  - required: next cycle all outputs 0 and state IDLE; a following read completes normally.
- LSU_AXI_BRIDGE_ERR_EN defined:
  - stimulus: rresp=10
  - required: io_err=1, io_rdata=0. With the macro undefined: io_err=0 and io_rdata equals rdata.

Source files
------------

// File: rtl/lsu_axi_bridge_pkg.sv
// lsu_axi_bridge_pkg
// Shared types and constants for the LSU-to-AXI4-Lite bridge:
//   state_t          bridge controller states
//   OKAY..DECERR     AXI response codes
//   AXI_SIZE_*       AXI transfer size encodings
//   lsu_to_axi_size  maps the LSU 2-bit io_size onto an AXI size
// Optional feature macro used by the bridge: LSU_AXI_BRIDGE_ERR_EN.

package lsu_axi_bridge_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_DATA = 3'd2,
        WR_REQ  = 3'd3,
        WR_RESP = 3'd4,
        RESP    = 3'd5
    } state_t;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] EXOKAY = 2'b01;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    localparam logic [2:0] AXI_SIZE_1B = 3'b000;
    localparam logic [2:0] AXI_SIZE_2B = 3'b001;
    localparam logic [2:0] AXI_SIZE_4B = 3'b010;

    // The LSU encodes word accesses as both 10 and 11.
    function automatic logic [2:0] lsu_to_axi_size(input logic [1:0] sz);
        logic [2:0] r;
        case (sz)
            2'b00:   r = AXI_SIZE_1B;
            2'b01:   r = AXI_SIZE_2B;
            default: r = AXI_SIZE_4B;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/lsu_axi_bridge_if.sv
// lsu_axi_bridge_if
// AXI4-Lite channel bundle between the bridge (master) and the interconnect
// (slave).
//   AW: awvalid/awready, awaddr[31:0], awsize[2:0]
//   W : wvalid/wready, wdata[31:0], wstrb[3:0]
//   B : bvalid/bready, bresp[1:0]
//   AR: arvalid/arready, araddr[31:0], arsize[2:0]
//   R : rvalid/rready, rdata[31:0], rresp[1:0]

interface lsu_axi_bridge_if;

    logic        awvalid;
    logic        awready;
    logic [31:0] awaddr;
    logic [2:0]  awsize;

    logic        wvalid;
    logic        wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;

    logic        bvalid;
    logic        bready;
    logic [1:0]  bresp;

    logic        arvalid;
    logic        arready;
    logic [31:0] araddr;
    logic [2:0]  arsize;

    logic        rvalid;
    logic        rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;

    modport master (
        output awvalid, awaddr, awsize, input awready,
        output wvalid, wdata, wstrb, input wready,
        input bvalid, bresp, output bready,
        output arvalid, araddr, arsize, input arready,
        input rvalid, rdata, rresp, output rready
    );

    modport slave (
        input awvalid, awaddr, awsize, output awready,
        input wvalid, wdata, wstrb, output wready,
        output bvalid, bresp, input bready,
        input arvalid, araddr, arsize, output arready,
        output rvalid, rdata, rresp, input rready
    );

endinterface

// File: rtl/lsu_axi_bridge_aw_w_join.sv
// axi_aw_w_join
// Issues AW and W together and lets each valid drop on its own handshake.
// Reports done in the cycle the second of the two handshakes completes
// (or both at once).
// Ports:
//   clock, reset        clock, synchronous active-low reset
//   start               one-cycle pulse: raise both valids next cycle
//   awready, wready     slave readies
//   awvalid, wvalid     registered valids
//   done                both channels accepted (combinational)

module axi_aw_w_join (
    input  logic clock,
    input  logic reset,
    input  logic start,
    input  logic awready,
    input  logic wready,
    output logic awvalid,
    output logic wvalid,
    output logic done
);

    logic aw_acc_q;
    logic w_acc_q;
    logic aw_done;
    logic w_done;

    // A channel counts as accepted once its handshake fires, including
    // the cycle in which it fires.
    assign aw_done = aw_acc_q | (awvalid & awready);
    assign w_done  = w_acc_q  | (wvalid  & wready);
    assign done    = aw_done & w_done;

    always_ff @(posedge clock) begin
        if (!reset) begin
            awvalid  <= 1'b0;
            wvalid   <= 1'b0;
            aw_acc_q <= 1'b0;
            w_acc_q  <= 1'b0;
        end else begin
            awvalid  <= start | (awvalid & ~awready);
            wvalid   <= start | (wvalid & ~wready);
            aw_acc_q <= aw_done & ~done;
            w_acc_q  <= w_done & ~done;
        end
    end

endmodule

// File: rtl/lsu_axi_bridge.sv
// lsu_axi_bridge
// Turns the LSU's single-outstanding io_* request/response port into an
// AXI4-Lite master. One request is latched in IDLE, the matching AXI read or
// write is run, and a one-cycle io_respValid pulse closes it. Addresses and
// data lanes pass through untouched.
// Ports:
//   clock, reset   clock, synchronous active-low reset
//   io_reqValid    one-cycle request pulse (ignored unless IDLE)
//   io_addr/size/wen/wdata/wmask  request fields
//   io_respValid   one-cycle completion pulse
//   io_rdata       last captured read word (held between reads)
//   io_err         error flag, valid with io_respValid
//   axi            AXI4-Lite master channels (lsu_axi_bridge_if.master)
// Macro LSU_AXI_BRIDGE_ERR_EN: when defined, a non-OKAY rresp/bresp raises
// io_err in the response cycle and a failed read returns zero data. When
// undefined, responses are ignored and io_err is tied low.

module lsu_axi_bridge
    import lsu_axi_bridge_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             io_reqValid,
    output logic             io_respValid,
    input  logic [31:0]      io_addr,
    input  logic [1:0]       io_size,
    input  logic             io_wen,
    input  logic [31:0]      io_wdata,
    input  logic [3:0]       io_wmask,
    output logic [31:0]      io_rdata,
    output logic             io_err,
    lsu_axi_bridge_if.master axi
);

    state_t state_q;
    state_t state_d;
    logic   req_fire;
    logic   wr_start;
    logic   aw_w_done;
    logic   rd_fire;

    assign req_fire = (state_q == IDLE) && io_reqValid;
    assign wr_start = req_fire && io_wen;
    assign rd_fire  = (state_q == RD_DATA) && axi.rvalid;

    axi_aw_w_join u_aw_w_join (
        .clock   (clock),
        .reset   (reset),
        .start   (wr_start),
        .awready (axi.awready),
        .wready  (axi.wready),
        .awvalid (axi.awvalid),
        .wvalid  (axi.wvalid),
        .done    (aw_w_done)
    );

`ifdef LSU_AXI_BRIDGE_ERR_EN
    logic err_d;
    logic err_q;
    assign io_err = err_q;
`else
    logic unused_resp;
    assign unused_resp = ^{axi.rresp, axi.bresp};
    assign io_err      = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
`ifdef LSU_AXI_BRIDGE_ERR_EN
        err_d   = 1'b0;
`endif
        case (state_q)
            IDLE:    if (io_reqValid) state_d = io_wen ? WR_REQ : RD_ADDR;
            RD_ADDR: if (axi.arready) state_d = RD_DATA;
            RD_DATA: if (axi.rvalid)  state_d = RESP;
            WR_REQ:  if (aw_w_done)   state_d = WR_RESP;
            WR_RESP: if (axi.bvalid)  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
`ifdef LSU_AXI_BRIDGE_ERR_EN
        if (rd_fire) begin
            err_d = (axi.rresp != OKAY);
        end else if ((state_q == WR_RESP) && axi.bvalid) begin
            err_d = (axi.bresp != OKAY);
        end
`endif
    end

    // Handshake outputs are registered copies of the next-state decode, so
    // every output comes straight from a flop.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= IDLE;
            axi.arvalid  <= 1'b0;
            axi.rready   <= 1'b0;
            axi.bready   <= 1'b0;
            io_respValid <= 1'b0;
            io_rdata     <= '0;
            axi.araddr   <= '0;
            axi.arsize   <= '0;
            axi.awaddr   <= '0;
            axi.awsize   <= '0;
            axi.wdata    <= '0;
            axi.wstrb    <= '0;
`ifdef LSU_AXI_BRIDGE_ERR_EN
            err_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            axi.arvalid  <= (state_d == RD_ADDR);
            axi.rready   <= (state_d == RD_DATA);
            axi.bready   <= (state_d == WR_RESP);
            io_respValid <= (state_d == RESP);
`ifdef LSU_AXI_BRIDGE_ERR_EN
            err_q        <= err_d;
`endif
            if (req_fire) begin
                if (io_wen) begin
                    axi.awaddr <= io_addr;
                    axi.awsize <= lsu_to_axi_size(io_size);
                    axi.wdata  <= io_wdata;
                    axi.wstrb  <= io_wmask;
                end else begin
                    axi.araddr <= io_addr;
                    axi.arsize <= lsu_to_axi_size(io_size);
                end
            end
            if (rd_fire) begin
`ifdef LSU_AXI_BRIDGE_ERR_EN
                io_rdata <= (axi.rresp != OKAY) ? 32'h0 : axi.rdata;
`else
                io_rdata <= axi.rdata;
`endif
            end
        end
    end

endmodule
